// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel register file: register-select
// offsets, the per-channel mode layout and the byte-pointer step helper.
package dma_pkg;

  // Offsets inside one channel's three-register group (select = 3*ch + off)
  localparam int unsigned OFF_ADDR  = 0;
  localparam int unsigned OFF_CNT   = 1;
  localparam int unsigned OFF_MODE  = 2;

  // Offsets of the global registers, relative to B = 3*NUM_CH
  localparam int unsigned OFF_CMD   = 0;  // W command, R status
  localparam int unsigned OFF_REQ   = 1;  // W single request
  localparam int unsigned OFF_SMASK = 2;  // W single mask
  localparam int unsigned OFF_AMASK = 3;  // W/R all-mask
  localparam int unsigned OFF_CLRBP = 4;  // W clear byte pointer
  localparam int unsigned OFF_MCLR  = 5;  // W master clear, R temp
  localparam int unsigned OFF_REQRD = 6;  // R request bits

  // Mode register as written from dataIn[5:0]
  typedef struct packed {
    logic [1:0] mode;
    logic       dec;
    logic       autoinit;
    logic [1:0] xfer;
  } mode_t;

  // Byte pointer successor, wrapping at the accessed register's byte count
  function automatic int unsigned next_byte(input int unsigned idx,
                                            input int unsigned nb);
    return (idx + 1 >= nb) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dma_chan_ctr.sv
// One channel's base/current address and count, with CPU byte writes,
// per-transfer stepping and autoinitialise reload.
module dma_chan_ctr #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int BP_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_addr,
  input  logic              wr_cnt,
  input  logic [BP_W-1:0]   byte_idx,
  input  logic [7:0]        wr_data,
  input  logic              step,
  input  logic              dec,
  input  logic              autoinit,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [CNT_W-1:0]  cur_cnt
);

  logic [ADDR_W-1:0] base_addr_q, base_addr_d, cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  base_cnt_q, base_cnt_d, cur_cnt_q, cur_cnt_d;

  // Step/reload first, then let a CPU byte override just the byte it hits
  always_comb begin
    base_addr_d = base_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_cnt_d   = cur_cnt_q;
    if (step) begin
      if ((cur_cnt_q == '0) && autoinit) begin
        cur_addr_d = base_addr_q;
        cur_cnt_d  = base_cnt_q;
      end else begin
        cur_addr_d = dec ? (cur_addr_q - ADDR_W'(1)) : (cur_addr_q + ADDR_W'(1));
        cur_cnt_d  = cur_cnt_q - CNT_W'(1);
      end
    end
    for (int b = 0; b < ADDR_W / 8; b++) begin
      if (wr_addr && (byte_idx == BP_W'(b))) begin
        base_addr_d[8*b +: 8] = wr_data;
        cur_addr_d[8*b +: 8]  = wr_data;
      end
    end
    for (int b = 0; b < CNT_W / 8; b++) begin
      if (wr_cnt && (byte_idx == BP_W'(b))) begin
        base_cnt_d[8*b +: 8] = wr_data;
        cur_cnt_d[8*b +: 8]  = wr_data;
      end
    end
  end

  // Channel register state
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr_q <= '0;
      base_cnt_q  <= '0;
      cur_addr_q  <= '0;
      cur_cnt_q   <= '0;
    end else begin
      base_addr_q <= base_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_addr_q  <= cur_addr_d;
      cur_cnt_q   <= cur_cnt_d;
    end
  end

  assign cur_addr = cur_addr_q;
  assign cur_cnt  = cur_cnt_q;

endmodule

// File: rtl/dma_chan_regfile.sv
// DMA register file: per-channel address/count/mode behind an 8-bit CPU
// port with a shared multi-byte pointer, plus command/request/mask/status/
// temp registers and the transfer-completion datapath updates.
module dma_chan_regfile
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(3*NUM_CH+7),
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  regWr,
  input  logic                  regRd,
  input  logic [SEL_W-1:0]      regSel,
  input  logic [7:0]            dataIn,
  output logic [7:0]            dataOut,
  input  logic                  updEn,
  input  logic [CH_W-1:0]       updCh,
  input  logic                  tempWe,
  input  logic [7:0]            tempIn,
  output logic [7:0]            cmdReg,
  output logic [6*NUM_CH-1:0]   modeFlat,
  output logic [NUM_CH-1:0]     maskReg,
  output logic [NUM_CH-1:0]     reqReg,
  output logic [ADDR_W-1:0]     curAddr,
  output logic [CNT_W-1:0]      curCount,
  output logic                  tc
);

  localparam int unsigned B      = 3 * NUM_CH;
  localparam int unsigned NB_A   = ADDR_W / 8;
  localparam int unsigned NB_C   = CNT_W / 8;
  localparam int unsigned NB_MAX = (NB_A > NB_C) ? NB_A : NB_C;
  localparam int          BP_W   = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        temp_q, temp_d;
  logic [7:0]        dout_q, dout_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [BP_W-1:0]   bp_q, bp_d;
  mode_t             mode_q [NUM_CH];
  mode_t             mode_d [NUM_CH];

  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt  [NUM_CH];
  logic [NUM_CH-1:0] wr_addr_en, wr_cnt_en, step_en, tc_vec, autoinit_vec;
  logic              rd_act, mb_acc, mclr;
  logic [BP_W-1:0]   acc_idx;
  int unsigned       acc_nb;

  // Decode multi-byte accesses and pick the byte the pointer addresses
  always_comb begin
    rd_act     = regRd & ~regWr;
    wr_addr_en = '0;
    wr_cnt_en  = '0;
    mb_acc     = 1'b0;
    acc_nb     = NB_A;
    for (int i = 0; i < NUM_CH; i++) begin
      autoinit_vec[i] = mode_q[i].autoinit;
      if (regSel == SEL_W'(3*i + OFF_ADDR)) begin
        mb_acc        = regWr | regRd;
        acc_nb        = NB_A;
        wr_addr_en[i] = regWr;
      end
      if (regSel == SEL_W'(3*i + OFF_CNT)) begin
        mb_acc       = regWr | regRd;
        acc_nb       = NB_C;
        wr_cnt_en[i] = regWr;
      end
    end
    acc_idx = (32'(bp_q) < acc_nb) ? bp_q : '0;
  end

  // Select the serviced channel and detect terminal count
  always_comb begin
    curAddr  = '0;
    curCount = '0;
    step_en  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (updCh == CH_W'(i)) begin
        curAddr    = ch_addr[i];
        curCount   = ch_cnt[i];
        step_en[i] = updEn;
      end
    end
    tc     = (|step_en) && (curCount == '0);
    tc_vec = tc ? step_en : '0;
  end

  // Channel counters
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_chan_ctr #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .BP_W   (BP_W)
    ) u_ctr (
      .clk      (CLK),
      .rst      (RESET),
      .wr_addr  (wr_addr_en[g]),
      .wr_cnt   (wr_cnt_en[g]),
      .byte_idx (acc_idx),
      .wr_data  (dataIn),
      .step     (step_en[g]),
      .dec      (mode_q[g].dec),
      .autoinit (mode_q[g].autoinit),
      .cur_addr (ch_addr[g]),
      .cur_cnt  (ch_cnt[g])
    );
  end

  // Control registers: CPU write, then read side effects, then TC, then master clear
  always_comb begin
    cmd_d    = cmd_q;
    temp_d   = temp_q;
    dout_d   = dout_q;
    status_d = status_q;
    req_d    = req_q;
    mask_d   = mask_q;
    bp_d     = bp_q;
    mode_d   = mode_q;
    mclr     = 1'b0;

    if (regWr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (regSel == SEL_W'(3*i + OFF_MODE)) mode_d[i] = mode_t'(dataIn[5:0]);
        if ((regSel == SEL_W'(B + OFF_REQ)) && (dataIn[2:0] == 3'(i)))
          req_d[i] = dataIn[7];
        if ((regSel == SEL_W'(B + OFF_SMASK)) && (dataIn[2:0] == 3'(i)))
          mask_d[i] = dataIn[7];
      end
      if (regSel == SEL_W'(B + OFF_CMD))   cmd_d  = dataIn;
      if (regSel == SEL_W'(B + OFF_AMASK)) mask_d = dataIn[NUM_CH-1:0];
      if (regSel == SEL_W'(B + OFF_CLRBP)) bp_d   = '0;
      if (regSel == SEL_W'(B + OFF_MCLR))  mclr   = 1'b1;
    end

    if (mb_acc) bp_d = BP_W'(next_byte(32'(acc_idx), acc_nb));

    if (rd_act) begin
      dout_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (regSel == SEL_W'(3*i + OFF_ADDR)) begin
          for (int b = 0; b < int'(NB_A); b++)
            if (acc_idx == BP_W'(b)) dout_d = ch_addr[i][8*b +: 8];
        end
        if (regSel == SEL_W'(3*i + OFF_CNT)) begin
          for (int b = 0; b < int'(NB_C); b++)
            if (acc_idx == BP_W'(b)) dout_d = ch_cnt[i][8*b +: 8];
        end
      end
      if (regSel == SEL_W'(B + OFF_CMD)) begin
        dout_d   = 8'(status_q);
        status_d = '0;
      end
      if (regSel == SEL_W'(B + OFF_AMASK)) dout_d = 8'(mask_q);
      if (regSel == SEL_W'(B + OFF_MCLR))  dout_d = temp_q;
      if (regSel == SEL_W'(B + OFF_REQRD)) dout_d = 8'(req_q);
    end

    // A new TC survives a same-cycle status read and beats a request write
    status_d = status_d | tc_vec;
    req_d    = req_d & ~tc_vec;
    mask_d   = mask_d | (tc_vec & ~autoinit_vec);

    if (tempWe) temp_d = tempIn;

    if (mclr) begin
      cmd_d    = '0;
      status_d = '0;
      req_d    = '0;
      temp_d   = '0;
      bp_d     = '0;
      mask_d   = '1;
    end
  end

  // Register state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_q    <= '0;
      temp_q   <= '0;
      dout_q   <= '0;
      status_q <= '0;
      req_q    <= '0;
      mask_q   <= '1;
      bp_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) mode_q[i] <= '0;
    end else begin
      cmd_q    <= cmd_d;
      temp_q   <= temp_d;
      dout_q   <= dout_d;
      status_q <= status_d;
      req_q    <= req_d;
      mask_q   <= mask_d;
      bp_q     <= bp_d;
      mode_q   <= mode_d;
    end
  end

  // Flatten mode registers for the priority/FSM blocks
  always_comb begin
    modeFlat = '0;
    for (int i = 0; i < NUM_CH; i++) modeFlat[6*i +: 6] = mode_q[i];
  end

  assign dataOut = dout_q;
  assign cmdReg  = cmd_q;
  assign maskReg = mask_q;
  assign reqReg  = req_q;

endmodule
